stream_fifo: RTL and testbench

Parametrised, first-word-fall-through FIFO with valid/ready handshakes on both sides, backed by a synchronous-read dual-port storage array. It replaces the fixed 8x1024 byte queue wherever the design buffers streams between producer and consumer blocks. Over the fixed queue it adds configurable width and depth, backpressure on both ports, occupancy and almost-full status, simultaneous push/pop, and a synchronous flush.

---
 rtl/stream_fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 24 ++
 rtl/stream_fifo.sv | 146 ++++++++++++++
 tb/tb_stream_fifo.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the stream FIFO: occupancy counter update classification.
package stream_fifo_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
        if (inc && !dec) return CNT_INC;
        if (dec && !inc) return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array with a registered read port.
// Kept reset-free so it can be replaced by an SRAM macro.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO: array storage plus a two-entry
// output buffer (head + skid) hiding the one-cycle read latency.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 1024,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(AFULL_THRESH);

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      arr_cnt_q, arr_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  head_vld_q, head_vld_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  skid_vld_q, skid_vld_d;

    logic                  push, pop, re;
    logic [1:0]            occ_after;
    logic [DATA_WIDTH-1:0] rdata;

    assign in_ready    = (count_q != CNT_FULL);
    assign out_valid   = head_vld_q;
    assign out_data    = head_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_FULL);
    assign almost_full = (count_q >= AFULL_LVL);

    assign push = in_valid & in_ready & ~flush;
    assign pop  = head_vld_q & out_ready & ~flush;

    // Buffer occupancy once this edge's pop and landing read settle;
    // a new read may only be issued if its data will have a slot.
    assign occ_after = 2'(head_vld_q) + 2'(skid_vld_q)
                     + 2'(inflight_q) - 2'(pop);
    assign re = ~flush & (arr_cnt_q != '0) & (occ_after < 2'd2);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .re    (re),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (pop) begin
            head_vld_d = skid_vld_q;
            skid_vld_d = 1'b0;
            if (skid_vld_q) head_d = skid_q;
        end
        if (inflight_q) begin
            if (!head_vld_d) begin
                head_d     = rdata;
                head_vld_d = 1'b1;
            end else begin
                skid_d     = rdata;
                skid_vld_d = 1'b1;
            end
        end

        wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d   = rd_ptr_q + ADDR_W'(re);
        inflight_d = re;

        unique case (cnt_op(push, pop))
            CNT_INC: count_d = count_q + 1'b1;
            CNT_DEC: count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        unique case (cnt_op(push, re))
            CNT_INC: arr_cnt_d = arr_cnt_q + 1'b1;
            CNT_DEC: arr_cnt_d = arr_cnt_q - 1'b1;
            default: arr_cnt_d = arr_cnt_q;
        endcase

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            arr_cnt_d  = '0;
            inflight_d = 1'b0;
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            arr_cnt_q  <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            arr_cnt_q  <= arr_cnt_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo (DEPTH=16): directed fill, stream,
// backpressure, flush and async-reset sequences.
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       empty, full, almost_full;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    stream_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Head of the FIFO must always equal the oldest accepted word.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_unexpected: got %0h expected none", out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb[0]));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r,
                        input logic f, output logic acc);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
        acc = v && in_ready && !f && rst_n;
        if (acc) sb.push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain(input string nm);
        logic acc;
        int k = 0;
        while ((sb.size() != 0 || count != 0) && k < 200) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, acc);
            k++;
        end
        chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({nm, "_count"}, 32'(count), 32'd0);
        chk({nm, "_empty"}, 32'(empty), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);

        // single word latency
        step(1'b1, 8'hA5, 1'b0, 1'b0, acc);
        chk("a5_acc", 32'(acc), 32'd1);
        chk("a5_count_n", 32'(count), 32'd1);
        chk("a5_valid_n", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("a5_valid_n1", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("a5_valid_n2", 32'(out_valid), 32'd1);
        chk("a5_data_n2", 32'(out_data), 32'hA5);
        drain("a5");

        // fill to full with consumer stalled
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, acc);
            chk("fill_acc", 32'(acc), 32'd1);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
            chk("fill_full", 32'(full), 32'(i == 15));
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 8'h99, 1'b0, 1'b0, acc);
        chk("push17_acc", 32'(acc), 32'd0);
        chk("push17_count", 32'(count), 32'd16);

        // full with simultaneous push attempt and pop
        step(1'b1, 8'h77, 1'b1, 1'b0, acc);
        chk("fullpop_acc", 32'(acc), 32'd0);
        chk("fullpop_count", 32'(count), 32'd15);
        chk("fullpop_in_ready", 32'(in_ready), 32'd1);
        chk("fullpop_full", 32'(full), 32'd0);
        drain("fill");

        // streaming at one word per cycle
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, acc);
            chk("stream_acc", 32'(acc), 32'd1);
            chk("stream_count", 32'(count), 32'((i < 2) ? i + 1 : 3));
            chk("stream_valid", 32'(out_valid), 32'(i >= 2));
        end
        drain("stream");

        // consumer ready toggling every cycle
        d = 8'h40;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, d, 1'(i % 2), 1'b0, acc);
            if (acc) d = d + 8'd1;
        end
        drain("bp");

        // flush with seven entries held
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, acc);
        chk("preflush_count", 32'(count), 32'd7);
        step(1'b1, 8'hEE, 1'b1, 1'b1, acc);
        sb.delete();
        chk("flush_acc", 32'(acc), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        step(1'b1, 8'h3C, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("postflush_valid_n1", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("postflush_valid_n2", 32'(out_valid), 32'd1);
        chk("postflush_data", 32'(out_data), 32'h3C);
        drain("flush");

        // asynchronous reset mid-transfer
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_empty", 32'(empty), 32'd1);
        sb.delete();
        out_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0, acc);
        chk("postrst_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("postrst_valid", 32'(out_valid), 32'd1);
        chk("postrst_data", 32'(out_data), 32'h5A);
        drain("rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
